avmm_host_wr_arbiter: RTL and testbench

AVMM_HOST_WR_ARBITER -- requirements
Module: avmm_host_wr_arbiter

---
 rtl/avmm_host_wr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_avmm_host_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_host_wr_arbiter.sv
// avmm_host_wr_arbiter
//   Round-robin arbiter folding NUM_CH Avalon-MM write hosts onto one
//   downstream burst-capable write master. Grant is decided combinationally
//   in IDLE (zero added latency) and held for the whole burst. The granted
//   channel index of every burst is queued so write responses coming back in
//   order can be routed to the channel that issued the burst.
//
// Ports
//   clk, reset               : sole clock, synchronous active-high reset
//   ch_write/address/...     : per-channel host write requests (slice i = ch i)
//   ch_waitrequest           : per-channel stall
//   ch_response/..valid      : routed write response
//   avmm_*                   : downstream write master / slave feedback
//   err_rsp_underflow        : sticky, response arrived with nothing tracked
//   stat_bursts              : per-channel completed-burst counters
//
// Build option
//   AVMM_HOST_WR_ARB_STATS_EN : when defined, builds saturating 32-bit
//   completed-burst counters; otherwise stat_bursts is tied to zero.
module avmm_host_wr_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 48,
  parameter int BURST_WIDTH    = 3,
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]  ch_address,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  ch_writedata,
  input  logic [NUM_CH*BURST_WIDTH-1:0] ch_burstcount,
  output logic [NUM_CH-1:0]           ch_waitrequest,
  output logic [NUM_CH*2-1:0]         ch_response,
  output logic [NUM_CH-1:0]           ch_writeresponsevalid,
  output logic                        avmm_write,
  output logic [ADDR_WIDTH-1:0]       avmm_address,
  output logic [DATA_WIDTH-1:0]       avmm_writedata,
  output logic [BURST_WIDTH-1:0]      avmm_burstcount,
  input  logic                        avmm_waitrequest,
  input  logic [1:0]                  avmm_response,
  input  logic                        avmm_writeresponsevalid,
  output logic                        err_rsp_underflow,
  output logic [NUM_CH*32-1:0]        stat_bursts
);

  localparam int IW  = $clog2(NUM_CH);
  localparam int FAW = $clog2(RSP_FIFO_DEPTH);
  localparam logic [FAW:0] DEPTH_C = (FAW+1)'(RSP_FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 r_state, w_state_nxt;
  logic [IW-1:0]          r_rr_ptr, r_grant, w_sel, w_gnt, w_rr_nxt, w_head;
  logic [BURST_WIDTH-1:0] r_beats_left, w_bc;
  logic                   w_any, w_full, w_acc, w_first, w_done, w_push, w_pop;
  logic [IW-1:0]          r_fifo [RSP_FIFO_DEPTH];
  logic [FAW-1:0]         r_wptr, r_rptr;
  logic [FAW:0]           r_count;
  logic                   r_uf;

  // channel-indexed views of the flat input buses
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]  w_addr_v;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  w_data_v;
  logic [NUM_CH-1:0][BURST_WIDTH-1:0] w_bc_v;
  assign w_addr_v = ch_address;
  assign w_data_v = ch_writedata;
  assign w_bc_v   = ch_burstcount;

  // round-robin search from r_rr_ptr; descending k lets the nearest win
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NUM_CH;
      if (ch_write[idx]) begin
        w_any = 1'b1;
        w_sel = IW'(idx);
      end
    end
  end

  assign w_full   = (r_count == DEPTH_C);
  assign w_gnt    = (r_state == S_IDLE) ? w_sel : r_grant;
  assign w_bc     = w_bc_v[w_gnt];
  assign w_rr_nxt = (w_gnt == IW'(NUM_CH-1)) ? '0 : w_gnt + 1'b1;
  assign w_head   = r_fifo[r_rptr];

  assign avmm_address    = w_addr_v[w_gnt];
  assign avmm_writedata  = w_data_v[w_gnt];
  assign avmm_burstcount = w_bc;

  assign w_acc   = avmm_write & ~avmm_waitrequest;
  assign w_first = w_acc & (r_state == S_IDLE);
  assign w_push  = w_first;
  // burstcount 0 and 1 both complete on the first beat
  assign w_done  = w_acc & (((r_state == S_IDLE)  && (w_bc <= BURST_WIDTH'(1))) ||
                            ((r_state == S_BURST) && (r_beats_left == BURST_WIDTH'(1))));
  assign w_pop   = avmm_writeresponsevalid & (r_count != '0) & ~reset;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc && (w_bc > BURST_WIDTH'(1)))            w_state_nxt = S_BURST;
      S_BURST: if (w_acc && (r_beats_left == BURST_WIDTH'(1)))   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. Occupancy is the registered count, so a pop in the
  // same cycle never releases a full-FIFO stall.
  always_comb begin
    avmm_write            = 1'b0;
    ch_waitrequest        = '1;
    ch_writeresponsevalid = '0;
    ch_response           = '0;
    if (!reset) begin
      if ((r_state == S_BURST) || (w_any && !w_full)) begin
        avmm_write            = ch_write[w_gnt];
        ch_waitrequest[w_gnt] = avmm_waitrequest;
      end
      if (w_pop) begin
        ch_writeresponsevalid[w_head] = 1'b1;
        ch_response[2*w_head +: 2]    = avmm_response;
      end
    end
  end

  // grant / burst / round-robin / tracking bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_beats_left <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_uf         <= 1'b0;
    end else begin
      if (w_first && (w_bc > BURST_WIDTH'(1))) begin
        r_grant      <= w_sel;
        r_beats_left <= w_bc - 1'b1;
      end else if (w_acc && (r_state == S_BURST)) begin
        r_beats_left <= r_beats_left - 1'b1;
      end
      if (w_done) r_rr_ptr <= w_rr_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (avmm_writeresponsevalid && (r_count == '0)) r_uf <= 1'b1;
    end
  end

  // tracking storage; validity is carried by the pointers alone
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end

  assign err_rsp_underflow = r_uf;

`ifdef AVMM_HOST_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
    logic [31:0] r_cnt;
    always_ff @(posedge clk) begin
      if (reset)                                                    r_cnt <= '0;
      else if (w_done && (w_gnt == IW'(i)) && (r_cnt != 32'hFFFF_FFFF)) r_cnt <= r_cnt + 1'b1;
    end
    assign stat_bursts[32*i +: 32] = r_cnt;
  end
`else
  assign stat_bursts = '0;
`endif

endmodule

// File: tb/tb_avmm_host_wr_arbiter.sv
module tb_avmm_host_wr_arbiter;
  localparam int NC = 4, DW = 32, AW = 16, BW = 3, DEP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     ch_write;
  logic [NC*AW-1:0]  ch_address;
  logic [NC*DW-1:0]  ch_writedata;
  logic [NC*BW-1:0]  ch_burstcount;
  logic [NC-1:0]     ch_waitrequest;
  logic [NC*2-1:0]   ch_response;
  logic [NC-1:0]     ch_writeresponsevalid;
  logic              avmm_write;
  logic [AW-1:0]     avmm_address;
  logic [DW-1:0]     avmm_writedata;
  logic [BW-1:0]     avmm_burstcount;
  logic              avmm_waitrequest;
  logic [1:0]        avmm_response;
  logic              avmm_writeresponsevalid;
  logic              err_rsp_underflow;
  logic [NC*32-1:0]  stat_bursts;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  avmm_host_wr_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                         .BURST_WIDTH(BW), .RSP_FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset),
    .ch_write(ch_write), .ch_address(ch_address), .ch_writedata(ch_writedata),
    .ch_burstcount(ch_burstcount), .ch_waitrequest(ch_waitrequest),
    .ch_response(ch_response), .ch_writeresponsevalid(ch_writeresponsevalid),
    .avmm_write(avmm_write), .avmm_address(avmm_address),
    .avmm_writedata(avmm_writedata), .avmm_burstcount(avmm_burstcount),
    .avmm_waitrequest(avmm_waitrequest), .avmm_response(avmm_response),
    .avmm_writeresponsevalid(avmm_writeresponsevalid),
    .err_rsp_underflow(err_rsp_underflow), .stat_bursts(stat_bursts));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner<0 means no burst in progress; queue holds the issuing channel of
  // every burst still awaiting its response.
  bit          m_en = 0;
  int          m_owner = -1, m_left = 0, m_rr = 0;
  int          m_q[$];
  bit          m_uf = 0;
  int unsigned m_cnt[NC];

  always @(negedge clk) begin
    logic          e_wr;
    logic [NC-1:0] e_wait, e_rv;
    logic [NC*2-1:0] e_rsp;
    int g, len;
    bit done;
    if (reset) m_en = 1;
    if (m_en) begin
      e_wr = 0; e_wait = '1; e_rv = '0; e_rsp = '0; g = -1; done = 0;
      if (!reset) begin
        if (m_owner >= 0) g = m_owner;
        else if (m_q.size() < DEP)
          for (int k = 0; k < NC; k++)
            if (g < 0 && ch_write[(m_rr + k) % NC]) g = (m_rr + k) % NC;
        if (g >= 0) begin e_wr = ch_write[g]; e_wait[g] = avmm_waitrequest; end
        if (avmm_writeresponsevalid && m_q.size() > 0) begin
          e_rv[m_q[0]] = 1'b1;
          e_rsp[2*m_q[0] +: 2] = avmm_response;
        end
      end
      chk("m_avmm_write", avmm_write, e_wr);
      chk("m_ch_waitrequest", ch_waitrequest, e_wait);
      chk("m_rsp_valid", ch_writeresponsevalid, e_rv);
      chk("m_rsp_code", ch_response, e_rsp);
      chk("m_underflow", err_rsp_underflow, m_uf);
      for (int i = 0; i < NC; i++) begin
`ifdef AVMM_HOST_WR_ARB_STATS_EN
        chk("m_stat", stat_bursts[32*i +: 32], m_cnt[i]);
`else
        chk("m_stat", stat_bursts[32*i +: 32], 0);
`endif
      end
      if (e_wr) begin
        chk("m_addr", avmm_address, ch_address[AW*g +: AW]);
        chk("m_data", avmm_writedata, ch_writedata[DW*g +: DW]);
        chk("m_bc", avmm_burstcount, ch_burstcount[BW*g +: BW]);
      end
      // advance to the state after the coming rising edge
      if (reset) begin
        m_owner = -1; m_left = 0; m_rr = 0; m_q.delete(); m_uf = 0;
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      end else begin
        if (avmm_writeresponsevalid) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          else m_uf = 1;
        end
        if (e_wr && !avmm_waitrequest) begin
          if (m_owner < 0) begin
            m_q.push_back(g);
            len = (ch_burstcount[BW*g +: BW] == 0) ? 1 : int'(ch_burstcount[BW*g +: BW]);
            if (len > 1) begin m_owner = g; m_left = len - 1; end
            else done = 1;
          end else begin
            m_left--;
            if (m_left == 0) begin done = 1; m_owner = -1; end
          end
          if (done) begin
            m_rr = (g + 1) % NC;
            if (m_cnt[g] != 32'hFFFF_FFFF) m_cnt[g]++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic do_reset(); reset = 1; cyc(); reset = 0; endtask

  int left[NC];
  logic [NC-1:0] acc;
  logic [1:0] rsp2;
  logic [31:0] st;

  initial begin
    reset = 1; ch_write = '1; avmm_waitrequest = 0; avmm_response = 0;
    avmm_writeresponsevalid = 1;
    ch_address = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    ch_writedata = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    ch_burstcount = {3'd1, 3'd1, 3'd1, 3'd1};
    cyc(); cyc(); #2;
    chk("rst_write", avmm_write, 0);
    chk("rst_wait", ch_waitrequest, 4'hF);
    chk("rst_rspvalid", ch_writeresponsevalid, 0);
    chk("rst_uf", err_rsp_underflow, 0);
    chk("rst_stat", stat_bursts, 0);
    ch_write = 0; avmm_writeresponsevalid = 0;
    cyc(); reset = 0;

    // continuous single beats from all channels -> 0,1,2,3,0
    ch_write = 4'hF; #2;
    chk("rr_g0", ch_waitrequest, 4'b1110); chk("rr_addr0", avmm_address, 16'h1000);
    cyc(); avmm_writeresponsevalid = 1; #2;
    chk("rr_g1", ch_waitrequest, 4'b1101); chk("rr_rsp0", ch_writeresponsevalid, 4'b0001);
    cyc(); #2; chk("rr_g2", ch_waitrequest, 4'b1011); chk("rr_rsp1", ch_writeresponsevalid, 4'b0010);
    cyc(); #2; chk("rr_g3", ch_waitrequest, 4'b0111); chk("rr_data3", avmm_writedata, 32'hD3D3_0003);
    cyc(); #2; chk("rr_g4", ch_waitrequest, 4'b1110);
    cyc(); ch_write = 0; #2; chk("rr_drain", ch_writeresponsevalid, 4'b0001);
    cyc(); avmm_writeresponsevalid = 0;

    // burst hold through a waitrequest stall
    do_reset();
    ch_write = 4'b0010; ch_burstcount[5:3] = 3'd4; #2;
    chk("bu_c0", ch_waitrequest, 4'b1101); chk("bu_bc", avmm_burstcount, 4);
    cyc(); ch_write = 4'b0011; #2; chk("bu_c1", ch_waitrequest, 4'b1101);
    cyc(); avmm_waitrequest = 1; #2; chk("bu_c2", ch_waitrequest, 4'b1111); chk("bu_c2_wr", avmm_write, 1);
    cyc(); avmm_waitrequest = 0; #2; chk("bu_c3", ch_waitrequest, 4'b1101);
    cyc(); #2; chk("bu_c4", ch_waitrequest, 4'b1101);
    cyc(); ch_write = 4'b0001; #2; chk("bu_c5_ch0", ch_waitrequest, 4'b1110);
    cyc(); ch_write = 0; ch_burstcount[5:3] = 3'd1;

    // tracking FIFO full, then released by one response
    do_reset();
    ch_write = 4'b0100; cyc(); ch_write = 4'b0001; cyc();
    ch_write = 4'b1000; cyc(); ch_write = 4'b0010; cyc();
    ch_write = 4'b0100; #2;
    chk("full_wr", avmm_write, 0); chk("full_wait", ch_waitrequest, 4'hF);
    cyc(); avmm_writeresponsevalid = 1; avmm_response = 2'b10; #2;
    rsp2 = ch_response[5:4];
    chk("full_rv", ch_writeresponsevalid, 4'b0100); chk("full_code", rsp2, 2'b10);
    chk("full_same_cyc", avmm_write, 0);
    cyc(); avmm_writeresponsevalid = 0; #2;
    chk("full_lift", avmm_write, 1); chk("full_lift_wait", ch_waitrequest, 4'b1011);
    cyc(); ch_write = 0;

    // response underflow is sticky until reset
    do_reset();
    avmm_writeresponsevalid = 1; #2; chk("uf_nostrobe", ch_writeresponsevalid, 0);
    cyc(); avmm_writeresponsevalid = 0; #2; chk("uf_set", err_rsp_underflow, 1);
    cyc(); cyc(); cyc(); #2; chk("uf_sticky", err_rsp_underflow, 1);
    do_reset(); #2; chk("uf_clr", err_rsp_underflow, 0);

    // reset during beat 2 of a 4-beat burst
    ch_write = 4'b0100; cyc();
    ch_write = 4'b0010; ch_burstcount[5:3] = 3'd4; #2; chk("mr_b1", ch_waitrequest, 4'b1101);
    cyc(); reset = 1; #2; chk("mr_rst_wr", avmm_write, 0);
    cyc(); reset = 0; ch_write = 0; avmm_writeresponsevalid = 1; #2;
    chk("mr_idle", avmm_write, 0); chk("mr_no_track", ch_writeresponsevalid, 0);
    chk("mr_stat0", stat_bursts, 0);
    cyc(); avmm_writeresponsevalid = 0; ch_write = 4'b1000; #2;
    chk("mr_ch3", ch_waitrequest, 4'b0111);
    cyc(); ch_write = 0; #2;
    st = stat_bursts[127:96];
`ifdef AVMM_HOST_WR_ARB_STATS_EN
    chk("mr_stat3", st, 1);
`else
    chk("mr_stat3", st, 0);
`endif
    cyc(); ch_write = 4'b1001; ch_burstcount[5:3] = 3'd1; #2;
    chk("mr_rr0", ch_waitrequest, 4'b1110);
    cyc(); ch_write = 0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < NC; i++) left[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      acc = reset ? '0 : (ch_write & ~ch_waitrequest);
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) begin
        if (reset) left[i] = 0;
        else if (acc[i]) begin
          left[i]--;
          ch_writedata[DW*i +: DW] = $urandom;
        end
        if (left[i] == 0 && ($urandom % 2 == 0)) begin
          ch_burstcount[BW*i +: BW] = BW'($urandom_range(0, 4));
          left[i] = (ch_burstcount[BW*i +: BW] == 0) ? 1 : int'(ch_burstcount[BW*i +: BW]);
          ch_address[AW*i +: AW]   = AW'($urandom);
          ch_writedata[DW*i +: DW] = $urandom;
        end
        ch_write[i] = (left[i] > 0);
      end
      avmm_waitrequest        = ($urandom % 10) < 3;
      avmm_writeresponsevalid = ($urandom % 4) == 0;
      avmm_response           = 2'($urandom);
      reset                   = ($urandom % 300) == 0;
    end
    reset = 0; ch_write = 0; avmm_writeresponsevalid = 0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
